// File: rtl/la_rrarb.sv
`default_nettype none
// ============================================================================
//  Module   : la_rrarb
//  Brief    : Round-robin arbiter with a registered one-hot grant. The grant
//             stays with its owner while the owner keeps requesting. An
//             optional hold limit forces a hand-over when others are waiting.
//  Revision : 1.0 - initial release
// ============================================================================
module la_rrarb #(
    parameter int N    = 4,
    parameter int HOLD = 0,
    parameter     PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         busy
);

    localparam int                 c_PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int                 c_CNT_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(N - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD  = c_CNT_W'(HOLD);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [N-1:0]       r_grant;
    logic               r_busy;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [N-1:0]       w_cand;
    logic               w_hi_found;
    logic [c_PTR_W-1:0] w_hi_idx;
    logic               w_found;
    logic [c_PTR_W-1:0] w_lo_idx;
    logic [c_PTR_W-1:0] w_win;
    logic [N-1:0]       w_win_oh;
    logic [c_PTR_W-1:0] w_ptr_adv;
    logic               w_idle;
    logic               w_owner_req;
    logic               w_at_hold;
    logic [N-1:0]       w_grant_nxt;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    // The current owner never competes: this handles both release (its req is
    // already low) and forced hand-over (it must be excluded).
    assign w_cand = req & ~r_grant;

    // Circular priority search: lowest candidate at or above ptr wins,
    // otherwise the lowest candidate overall (the wrapped part of the ring).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_found    = 1'b0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found  = 1'b1;
                w_lo_idx = c_PTR_W'(i);
                if (c_PTR_W'(i) >= r_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = c_PTR_W'(i);
                end
            end
        end
        w_win = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // Winner decode and pointer advance; the wrap is modulo N, not 2^width.
    always_comb begin
        w_win_oh = '0;
        for (int i = 0; i < N; i++) begin
            w_win_oh[i] = (w_win == c_PTR_W'(i));
        end
        w_ptr_adv = (w_win == c_LAST) ? '0 : w_win + 1'b1;
    end

    assign w_idle      = ~|r_grant;
    assign w_owner_req = |(req & r_grant);
    assign w_at_hold   = (HOLD > 0) && (r_cnt == c_HOLD);

    // Next grant / pointer / hold count, from idle, held or released ownership.
    always_comb begin
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        if (w_idle) begin
            if (en && w_found) begin
                w_grant_nxt = w_win_oh;
                w_ptr_nxt   = w_ptr_adv;
                w_cnt_nxt   = c_ONE;
            end
        end else if (w_owner_req) begin
            if (en && w_at_hold && w_found) begin
                w_grant_nxt = w_win_oh;
                w_ptr_nxt   = w_ptr_adv;
                w_cnt_nxt   = c_ONE;
            end else if ((HOLD > 0) && (r_cnt != c_HOLD)) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end else begin
            if (en && w_found) begin
                w_grant_nxt = w_win_oh;
                w_ptr_nxt   = w_ptr_adv;
                w_cnt_nxt   = c_ONE;
            end else begin
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        end
    end

    // Arbiter state registers; busy is registered alongside grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_grant <= w_grant_nxt;
            r_busy  <= |w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_la_rrarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_la_rrarb
//  Brief    : Directed self-checking bench for la_rrarb (N=4/HOLD=0,
//             N=4/HOLD=3 and N=5/HOLD=0 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_la_rrarb;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] req0, req3, grant0, grant3;
    logic [4:0] req5, grant5;
    logic       busy0, busy3, busy5;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    la_rrarb #(.N(4), .HOLD(0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .req(req0), .grant(grant0), .busy(busy0));
    la_rrarb #(.N(4), .HOLD(3)) u_dut3 (
        .clk(clk), .reset(reset), .en(en), .req(req3), .grant(grant3), .busy(busy3));
    la_rrarb #(.N(5), .HOLD(0)) u_dut5 (
        .clk(clk), .reset(reset), .en(en), .req(req5), .grant(grant5), .busy(busy5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0  = '0;
        req3  = '0;
        req5  = '0;
        en    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("reset_grant0", 32'(grant0), 32'h0);
        check("reset_busy0", 32'(busy0), 32'h0);
        check("reset_grant5", 32'(grant5), 32'h0);

        // Sticky grant with all requesting.
        en   = 1'b1;
        req0 = 4'b1111;
        step();
        check("a_first", 32'(grant0), 32'h1);
        check("a_busy", 32'(busy0), 32'h1);
        step();
        step();
        check("a_sticky", 32'(grant0), 32'h1);

        // Owner drops for a cycle: back-to-back rotation.
        req0 = 4'b1110; step(); check("rot_1", 32'(grant0), 32'h2);
        req0 = 4'b1101; step(); check("rot_2", 32'(grant0), 32'h4);
        req0 = 4'b1011; step(); check("rot_3", 32'(grant0), 32'h8);
        req0 = 4'b0111; step(); check("rot_0", 32'(grant0), 32'h1);
        check("rot_busy", 32'(busy0), 32'h1);

        // Hold limit on the HOLD=3 instance.
        do_reset();
        en   = 1'b1;
        req3 = 4'b0101;
        for (int c = 1; c <= 7; c++) begin
            step();
            check($sformatf("hold_c%0d", c), 32'(grant3), (c <= 3 || c == 7) ? 32'h1 : 32'h4);
        end
        req3 = 4'b0001;
        for (int c = 0; c < 6; c++) step();
        check("hold_alone", 32'(grant3), 32'h1);

        // Enable gating.
        do_reset();
        en   = 1'b0;
        req0 = 4'b0010;
        step();
        step();
        check("en0_nogrant", 32'(grant0), 32'h0);
        en = 1'b1;
        step();
        check("en1_grant", 32'(grant0), 32'h2);
        en = 1'b0;
        step();
        check("en0_held", 32'(grant0), 32'h2);
        req0 = 4'b0000;
        step();
        check("en0_release", 32'(grant0), 32'h0);
        check("en0_busy", 32'(busy0), 32'h0);

        // Asynchronous reset mid-grant, then pointer restart.
        do_reset();
        en   = 1'b1;
        req0 = 4'b0100;
        step();
        check("pre_async", 32'(grant0), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 32'(grant0), 32'h0);
        check("async_busy", 32'(busy0), 32'h0);
        #2;
        reset = 1'b0;
        req0  = 4'b1100;
        step();
        check("post_async", 32'(grant0), 32'h4);

        // N=5 pointer wrap.
        do_reset();
        en   = 1'b1;
        req5 = 5'b10000;
        step();
        check("n5_own4", 32'(grant5), 32'h10);
        req5 = 5'b00011;
        step();
        check("n5_wrap", 32'(grant5), 32'h01);
        req5 = 5'b00010;
        step();
        check("n5_next", 32'(grant5), 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
